// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings.
// The slave side is the sequencer; the master side drives locked/relock_req.
interface pll_lock_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             locked;
  logic             relock_req;
  logic             pll_rst;
  logic             core_rst;
  logic             ready;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] lost_cnt;

  modport master (
    output locked, relock_req,
    input  pll_rst, core_rst, ready, fail_cnt, lost_cnt
  );

  modport slave (
    input  locked, relock_req,
    output pll_rst, core_rst, ready, fail_cnt, lost_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: resets the PLL, waits for a stable lock, releases the
// core, and re-initialises the PLL on timeout, lock loss or explicit request.
module pll_lock_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  pll_lock_sequencer_if.slave pll
);

  localparam int unsigned T_MAX0 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned T_MAX  = (T_MAX0 > STABLE_CYCLES) ? T_MAX0 : STABLE_CYCLES;
  localparam int unsigned TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0]    RST_LAST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]    WAIT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STAB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       fail_q, fail_d;
  logic [CNT_W-1:0]       lost_q, lost_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   core_rst_q, core_rst_d;
  logic                   ready_q, ready_d;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pll.locked};
  end

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    lost_d  = lost_q;

    // A relock request outranks every other exit, including the lost-lock count.
    if (state_q != RESET_PLL && pll.relock_req) begin
      state_d = RESET_PLL;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (timer_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (timer_q == WAIT_LAST) begin
            state_d = RESET_PLL;
            if (fail_q != CNT_MAX) fail_d = fail_q + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (timer_q == STAB_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            if (lost_q != CNT_MAX) lost_d = lost_q + CNT_W'(1);
          end
        end
      endcase
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == RUN) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    // Outputs decode the next state so they land on the same edge as the state.
    pll_rst_d  = (state_d == RESET_PLL);
    core_rst_d = (state_d != RUN);
    ready_d    = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_PLL;
      timer_q    <= '0;
      sync_q     <= '0;
      fail_q     <= '0;
      lost_q     <= '0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sync_q     <= sync_d;
      fail_q     <= fail_d;
      lost_q     <= lost_d;
      pll_rst_q  <= pll_rst_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
    end
  end

  assign pll.pll_rst  = pll_rst_q;
  assign pll.core_rst = core_rst_q;
  assign pll.ready    = ready_q;
  assign pll.fail_cnt = fail_q;
  assign pll.lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed edge-numbered scenarios plus random
// lock/relock traffic, all checked against an edge-history reference model.
module tb_pll_lock_sequencer;

  localparam int SYNC  = 2;
  localparam int PRC   = 4;
  localparam int TO    = 20;
  localparam int SC    = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam int M_RP  = 0;
  localparam int M_WL  = 1;
  localparam int M_ST  = 2;
  localparam int M_RUN = 3;

  logic clk;
  logic rst_n;

  pll_lock_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_sequencer #(
    .SYNC_STAGES   (SYNC),
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (SC),
    .CNT_W         (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pll  (bus)
  );

  int checks   = 0;
  int failures = 0;

  int e    = 0;
  int mode = M_RP;
  int age  = 0;
  int mf   = 0;
  int ml   = 0;
  bit hist[int];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, act, req);
    end
  endtask

  // Reference model: lock view is the raw locked sample taken SYNC edges earlier.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0; mode = M_RP; age = 0; mf = 0; ml = 0;
        hist.delete();
      end else begin
        int  nxt;
        bit  ls;
        e++;
        hist[e] = bus.locked;
        ls = (e - SYNC >= 1) ? hist[e - SYNC] : 1'b0;
        nxt = mode;
        if (mode != M_RP && bus.relock_req) begin
          nxt = M_RP;
        end else if (mode == M_RP) begin
          if (age == PRC - 1) nxt = M_WL;
        end else if (mode == M_WL) begin
          if (ls) nxt = M_ST;
          else if (age == TO - 1) begin
            nxt = M_RP;
            mf  = (mf < CMAX) ? mf + 1 : CMAX;
          end
        end else if (mode == M_ST) begin
          if (!ls) nxt = M_WL;
          else if (age == SC - 1) nxt = M_RUN;
        end else begin
          if (!ls) begin
            nxt = M_WL;
            ml  = (ml < CMAX) ? ml + 1 : CMAX;
          end
        end
        age  = (nxt != mode) ? 0 : age + 1;
        mode = nxt;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("pll_rst",  int'(bus.pll_rst),  (mode == M_RP)  ? 1 : 0);
      chk("core_rst", int'(bus.core_rst), (mode != M_RUN) ? 1 : 0);
      chk("ready",    int'(bus.ready),    (mode == M_RUN) ? 1 : 0);
      chk("fail_cnt", int'(bus.fail_cnt), mf);
      chk("lost_cnt", int'(bus.lost_cnt), ml);
    end
  end

  task automatic wait_to(input int k);
    int guard = 0;
    while (e < k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("edge_reach", e, k);
  endtask

  task automatic do_reset(input logic lk);
    rst_n          = 1'b0;
    bus.locked     = lk;
    bus.relock_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.locked     = 1'b0;
    bus.relock_req = 1'b0;

    // Lock present from reset, then loss, relock request and STABLE glitch.
    do_reset(1'b1);
    wait_to(3);  chk("s1_pll_rst_e3", int'(bus.pll_rst), 1);
    wait_to(4);  chk("s1_pll_rst_e4", int'(bus.pll_rst), 0);
    wait_to(5);  chk("s1_model_st_e5", mode, M_ST);
    wait_to(12); chk("s1_ready_e12", int'(bus.ready), 0);
    wait_to(13); chk("s1_ready_e13", int'(bus.ready), 1);
                 chk("s1_core_rst_e13", int'(bus.core_rst), 0);
                 chk("s1_fail_e13", int'(bus.fail_cnt), 0);
    wait_to(30); bus.locked = 1'b0;
    wait_to(32); chk("s3_ready_e32", int'(bus.ready), 1);
    wait_to(33); chk("s3_ready_e33", int'(bus.ready), 0);
                 chk("s3_core_rst_e33", int'(bus.core_rst), 1);
                 chk("s3_lost_e33", int'(bus.lost_cnt), 1);
    wait_to(34); bus.locked = 1'b1;
    wait_to(44); chk("s3_ready_e44", int'(bus.ready), 0);
    wait_to(45); chk("s3_ready_e45", int'(bus.ready), 1);
    wait_to(49); bus.locked = 1'b0;
    wait_to(51); bus.relock_req = 1'b1;
    wait_to(52); bus.relock_req = 1'b0; bus.locked = 1'b1;
                 chk("s5_pll_rst_e52", int'(bus.pll_rst), 1);
                 chk("s5_lost_e52", int'(bus.lost_cnt), 1);
    wait_to(53); bus.relock_req = 1'b1;
    wait_to(54); bus.relock_req = 1'b0;
    wait_to(55); chk("s5_pll_rst_e55", int'(bus.pll_rst), 1);
    wait_to(56); chk("s5_pll_rst_e56", int'(bus.pll_rst), 0);
    wait_to(58); bus.locked = 1'b0;
    wait_to(60); chk("s4_model_st_e60", mode, M_ST);
    wait_to(61); bus.locked = 1'b1;
    wait_to(71); chk("s4_ready_e71", int'(bus.ready), 0);
    wait_to(72); chk("s4_ready_e72", int'(bus.ready), 1);
                 chk("s4_lost_e72", int'(bus.lost_cnt), 1);
                 chk("s4_fail_e72", int'(bus.fail_cnt), 0);

    // No lock at all: repeated timeouts and counter saturation.
    do_reset(1'b0);
    wait_to(3);   chk("s2_pll_rst_e3", int'(bus.pll_rst), 1);
    wait_to(4);   chk("s2_pll_rst_e4", int'(bus.pll_rst), 0);
    wait_to(23);  chk("s2_pll_rst_e23", int'(bus.pll_rst), 0);
    wait_to(24);  chk("s2_pll_rst_e24", int'(bus.pll_rst), 1);
                  chk("s2_fail_e24", int'(bus.fail_cnt), 1);
    wait_to(47);  chk("s2_fail_e47", int'(bus.fail_cnt), 1);
    wait_to(48);  chk("s2_fail_e48", int'(bus.fail_cnt), 2);
    wait_to(72);  chk("s2_fail_e72", int'(bus.fail_cnt), 3);
    wait_to(100); chk("s2_fail_sat", int'(bus.fail_cnt), 3);

    // Asynchronous reset in WAIT_LOCK with two failures logged.
    do_reset(1'b0);
    wait_to(55);  chk("s6_fail_pre", int'(bus.fail_cnt), 2);
                  chk("s6_model_wl", mode, M_WL);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_pll_rst",  int'(bus.pll_rst),  1);
    chk("s6_core_rst", int'(bus.core_rst), 1);
    chk("s6_ready",    int'(bus.ready),    0);
    chk("s6_fail",     int'(bus.fail_cnt), 0);
    chk("s6_lost",     int'(bus.lost_cnt), 0);

    // Random lock behaviour with occasional relock requests.
    do_reset(1'b0);
    for (int i = 0; i < 1500; ) begin
      logic lvl;
      int   len;
      lvl = ($urandom_range(0, 2) != 0);
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        bus.locked     = lvl;
        bus.relock_req = ($urandom_range(0, 63) == 0);
        @(negedge clk);
        i++;
      end
    end
    bus.relock_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Control-side partner of the core PLL wrapper.
- Drives the PLL's active-high `rst` and consumes its asynchronous `locked` output.
- Holds the core in reset until lock has been continuously stable for a set time.
- Re-initialises the PLL when lock is not reached within a timeout, and counts lock failures and lock losses for diagnostics.
- Runs on the 50 MHz board reference clock (the same `refclk` that feeds the PLL), so it keeps running while the PLL is in reset or unlocked.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages in the `locked` synchroniser (≥2).
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held in state RESET_PLL.
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before the PLL is reset again (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before the core is released.
- `CNT_W`, 8: width of the diagnostic counters.

Ports:
- `clk`  in  1  50 MHz reference clock, the same net as the PLL `refclk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `locked`  in  1  PLL lock flag, asynchronous to `clk`.
- `relock_req`  in  1  synchronous one-cycle request to re-initialise the PLL.
- `pll_rst`  out  1  active-high reset to the PLL.
- `core_rst`  out  1  active-high reset for the core. The core re-synchronises it into the `outclk_0` domain.
- `ready`  out  1  high while in state RUN.
- `fail_cnt`  out  CNT_W  saturating count of lock timeouts.
- `lost_cnt`  out  CNT_W  saturating count of lock losses while in RUN.

## Operation
- `locked` passes through a `SYNC_STAGES`-deep synchroniser; its output is `locked_s`. The state machine sees only `locked_s`.
- One shared timer, cleared on every state change, counts 0..N-1. A state exits on the cycle the timer equals N-1.
- States:
  - RESET_PLL: entered at reset. After `PLL_RST_CYCLES` cycles → WAIT_LOCK. `locked_s` is ignored here.
  - WAIT_LOCK: if `locked_s`=1 → STABLE. If the timer reaches `LOCK_TIMEOUT`-1 with no lock → RESET_PLL and `fail_cnt`+1.
  - STABLE: if `locked_s`=0 → WAIT_LOCK (timer restarts, no counter change). After `STABLE_CYCLES` consecutive cycles → RUN.
  - RUN: if `locked_s`=0 → WAIT_LOCK and `lost_cnt`+1.
- `relock_req`=1 in any state except RESET_PLL → RESET_PLL. It takes priority over every other transition in the same cycle. It is ignored while in RESET_PLL and does not restart that state's timer.
- Output decode:
  - `pll_rst`=1 iff state is RESET_PLL.
  - `core_rst`=0 and `ready`=1 iff state is RUN.
- Counters saturate at 2^CNT_W-1 and are cleared only by `rst_n`.

## Timing
- All outputs are registered and update on the same edge as the state register, with no combinational paths from inputs. `pll_rst` must be glitch-free.
- Reset values: state RESET_PLL, timer 0, synchroniser all 0, `pll_rst`=1, `core_rst`=1, `ready`=0, `fail_cnt`=0, `lost_cnt`=0.
- Edge numbering: edge k is the k-th rising `clk` edge after `rst_n` deasserts.
  - `pll_rst` falls at edge `PLL_RST_CYCLES`.
  - `locked` → `locked_s` latency is `SYNC_STAGES` edges.
- Lock loss in RUN: `core_rst` rises and `ready` falls on the edge where `locked_s` is first seen low, i.e. `SYNC_STAGES`+1 edges after `locked` falls.
- Asserting `rst_n` mid-operation immediately forces all reset values, including the counters.
- A `locked` pulse shorter than one `clk` period may be missed; no capture of such pulses is required.

## Test plan
All scenarios use `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `CNT_W`=2.
- `locked` held at 1 from reset → `pll_rst` falls at edge 4; STABLE entered at edge 5; `ready`=1 and `core_rst`=0 from edge 13; both counters stay 0.
- `locked` held at 0 → `pll_rst` high during edges 1–3, low during edges 4–23, high again from edge 24 with `fail_cnt`=1; `fail_cnt`=2 at edge 48; `fail_cnt` saturates at 3 and never wraps.
- In RUN, drop `locked` at edge 30 → `core_rst`=1 and `ready`=0 from edge 33, `lost_cnt`=1; restore `locked` → `ready` returns 9 edges after `locked_s` is seen high.
- `locked` glitches low for 3 cycles while in STABLE → STABLE restarts with its full 8-cycle count after relock; `lost_cnt` and `fail_cnt` stay unchanged.
- `relock_req` pulsed in RUN in the same cycle that `locked_s` falls → next state RESET_PLL, `lost_cnt` unchanged, `pll_rst` high for exactly 4 cycles; a second `relock_req` during RESET_PLL does not extend it.
- Assert `rst_n` mid-WAIT_LOCK with `fail_cnt`=2 → all outputs immediately take their reset values, and `fail_cnt` reads 0.
